// File: rtl/word_serializer.sv
// word_serializer: turns WORD_SIZE-bit words into a gap-free 8-bit byte stream.
// Byte 0 (bits [7:0]) is sent first.
// A one-word pending buffer lets the source hand over the next word while the
// current word is still shifting out, so back-to-back words need no idle cycle.
// Every output is decoded from registered state only. No input has a
// combinational path to any output.
module word_serializer #(
    parameter int WORD_SIZE = 256,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_byte,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_first,
    output logic                 out_last,
    output logic [CNT_W-1:0]     words_sent,
    output logic                 busy
);

    localparam int BYTE_CNT = WORD_SIZE / 8;
    localparam int IDX_W    = $clog2(BYTE_CNT);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(1'b0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTE_CNT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 state_r, state_s;
    logic [WORD_SIZE-1:0]   cur_r, cur_s;
    logic [WORD_SIZE-1:0]   pend_r, pend_s;
    logic                   pend_vld_r, pend_vld_s;
    logic [IDX_W-1:0]       idx_r, idx_s;
    logic [CNT_W-1:0]       words_r, words_s;

    logic                   accept_s;
    logic                   xfer_s;
    logic                   last_s;

    // Handshake qualifiers derived from registered state and the current inputs.
    always_comb begin
        accept_s = in_valid & ~pend_vld_r;
        xfer_s   = (state_r == ST_SEND) & out_ready;
        last_s   = (idx_r == IDX_LAST);
    end

    // Next-state logic for the FSM, the word registers, the byte index and the counter.
    always_comb begin
        state_s    = state_r;
        cur_s      = cur_r;
        pend_s     = pend_r;
        pend_vld_s = pend_vld_r;
        idx_s      = idx_r;
        words_s    = words_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cur_s   = in_data;
                    idx_s   = IDX_ZERO;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (xfer_s && last_s) begin
                    words_s = words_r + CNT_W'(1'b1);
                    if (pend_vld_r) begin
                        // The pending word takes over with no bubble.
                        cur_s      = pend_r;
                        idx_s      = IDX_ZERO;
                        pend_vld_s = 1'b0;
                    end else if (accept_s) begin
                        // The word arriving on the final byte loads straight into cur.
                        cur_s = in_data;
                        idx_s = IDX_ZERO;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    if (xfer_s) begin
                        idx_s = idx_r + IDX_ONE;
                    end else begin
                        idx_s = idx_r;
                    end
                    if (accept_s) begin
                        pend_s     = in_data;
                        pend_vld_s = 1'b1;
                    end else begin
                        pend_vld_s = pend_vld_r;
                    end
                end
            end
            default: begin
                state_s    = ST_IDLE;
                pend_vld_s = 1'b0;
                idx_s      = IDX_ZERO;
            end
        endcase
    end

    // State register. Reset discards any in-flight or pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cur_r      <= {WORD_SIZE{1'b0}};
            pend_r     <= {WORD_SIZE{1'b0}};
            pend_vld_r <= 1'b0;
            idx_r      <= IDX_ZERO;
            words_r    <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            cur_r      <= cur_s;
            pend_r     <= pend_s;
            pend_vld_r <= pend_vld_s;
            idx_r      <= idx_s;
            words_r    <= words_s;
        end
    end

    // Output decode, driven purely from registered state.
    always_comb begin
        in_ready   = ~pend_vld_r;
        out_valid  = (state_r == ST_SEND);
        out_byte   = cur_r[{idx_r, 3'b000} +: 8];
        out_first  = (state_r == ST_SEND) & (idx_r == IDX_ZERO);
        out_last   = (state_r == ST_SEND) & (idx_r == IDX_LAST);
        words_sent = words_r;
        busy       = (state_r == ST_SEND) | pend_vld_r;
    end

endmodule
